// File: rtl/matvec_pkg.sv
// Shared types and sizing helpers for the matrix-vector sequencer.
package matvec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    OUT,
    FIN
  } state_t;

  // Width of the signed accumulator.
  // A full-width product plus enough headroom to sum one row without overflow.
  function automatic int acc_width(input int data_w, input int cols);
    return 2 * data_w + $clog2(cols);
  endfunction

  // Index width for a range of n entries.
  // The result is never zero, so a single-entry range still gets a 1-bit index.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// Registered signed multiply-accumulate.
// clear_first restarts the sum with the current product.
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COLS   = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic                                      clear_first,
  input  logic signed [DATA_W-1:0]                  a,
  input  logic signed [DATA_W-1:0]                  b,
  output logic signed [acc_width(DATA_W, COLS)-1:0] acc
);

  localparam int ACC_W = acc_width(DATA_W, COLS);

  logic signed [2*DATA_W-1:0] prod_p1;

  // Sign-extend a full-width product into the accumulator domain.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [2*DATA_W-1:0] p);
    return ACC_W'(p);
  endfunction

  // ---- stage p1: data returned by the stores, multiply and accumulate ----
  assign prod_p1 = a * b;

  // Accumulate on every tagged return.
  // The first column of a row overwrites the previous row's sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clear_first ? sext(prod_p1) : acc + sext(prod_p1);
    end
  end

endmodule

// File: rtl/matvec_sequencer.sv
// Row-by-row matrix-vector sequencer.
// Walks W (row-major) and x, accumulates each row, and offers it on a valid/ready port.
module matvec_sequencer
  import matvec_pkg::*;
#(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int DATA_W = 8
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      rd_en,
  output logic [addr_w(ROWS*COLS)-1:0]              w_addr,
  output logic [addr_w(COLS)-1:0]                   x_addr,
  input  logic signed [DATA_W-1:0]                  w_data,
  input  logic signed [DATA_W-1:0]                  x_data,
  output logic signed [acc_width(DATA_W, COLS)-1:0] y_data,
  output logic [addr_w(ROWS)-1:0]                   y_row,
  output logic                                      y_valid,
  input  logic                                      y_ready
);

  localparam int RW = addr_w(ROWS);
  localparam int CW = addr_w(COLS);

  state_t        state;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic          rd_en_p1;
  logic          first_p1;

  // Control FSM with registered outputs.
  // Addresses are loaded one edge ahead, so each rd_en cycle already carries r*COLS+c.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      w_addr  <= '0;
      x_addr  <= '0;
      y_row   <= '0;
      y_valid <= 1'b0;
      r       <= '0;
      c       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            r      <= '0;
            c      <= '0;
            rd_en  <= 1'b1;
            w_addr <= '0;
            x_addr <= '0;
          end
        end
        RUN: begin
          if (c == CW'(COLS - 1)) begin
            state <= WAIT;
            rd_en <= 1'b0;
          end else begin
            c      <= c + 1'b1;
            rd_en  <= 1'b1;
            w_addr <= w_addr + 1'b1;
            x_addr <= c + 1'b1;
          end
        end
        WAIT: begin
          state   <= OUT;
          y_valid <= 1'b1;
          y_row   <= r;
        end
        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (r == RW'(ROWS - 1)) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              // W is contiguous, so the next row starts one past the last address
              state  <= RUN;
              r      <= r + 1'b1;
              c      <= '0;
              rd_en  <= 1'b1;
              w_addr <= w_addr + 1'b1;
              x_addr <= '0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: tag travels with the one-cycle store latency ----
  // Delay the read strobe and the first-column flag to line up with returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_p1 <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      rd_en_p1 <= rd_en;
      first_p1 <= rd_en && (x_addr == '0);
    end
  end

  matvec_mac #(
    .DATA_W (DATA_W),
    .COLS   (COLS)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .en          (rd_en_p1),
    .clear_first (first_p1),
    .a           (w_data),
    .b           (x_data),
    .acc         (y_data)
  );

endmodule

// File: tb/tb_matvec_sequencer.sv
// Bench for matvec_sequencer.
// Uses a table of matrix/vector cases, a registered store model and a result scoreboard.
module tb_matvec_sequencer;

  localparam int ACC_W = 18;

  typedef struct packed {
    logic [8:0][7:0]       w;
    logic [2:0][7:0]       x;
    logic [2:0][ACC_W-1:0] y;
  } vec_t;

  typedef struct packed {
    logic [1:0]              row;
    logic signed [ACC_W-1:0] y;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    busy, done, rd_en, y_valid, y_ready;
  logic [3:0]              w_addr;
  logic [1:0]              x_addr, y_row;
  logic signed [7:0]       w_data, x_data;
  logic signed [ACC_W-1:0] y_data;

  logic signed [7:0] wmem [16];
  logic signed [7:0] xmem [4];
  vec_t              tbl [5];
  exp_t              sb [$];

  int cyc = 0;
  int ncmp = 0;
  int nfail = 0;
  int rd_count, hs_count, done_count, first_valid, done_cyc, addr_idx;

  matvec_sequencer #(.ROWS(3), .COLS(3), .DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .w_addr  (w_addr),
    .x_addr  (x_addr),
    .w_data  (w_data),
    .x_data  (x_data),
    .y_data  (y_data),
    .y_row   (y_row),
    .y_valid (y_valid),
    .y_ready (y_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Store model: data is returned one cycle after rd_en, filler otherwise.
  always @(posedge clk) begin
    if (rd_en) begin
      w_data <= wmem[w_addr];
      x_data <= xmem[x_addr];
    end else begin
      w_data <= 8'sh5A;
      x_data <= -8'sh33;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_y_valid"}, y_valid, 0);
    check({tag, "_w_addr"}, w_addr, 0);
    check({tag, "_x_addr"}, x_addr, 0);
    check({tag, "_y_data"}, y_data, 0);
    check({tag, "_y_row"}, y_row, 0);
  endtask

  // Monitor: address trace, handshakes and scoreboard compare, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (rd_en) begin
        check("w_addr_trace", w_addr, addr_idx);
        check("x_addr_trace", x_addr, addr_idx % 3);
        addr_idx++;
        rd_count++;
      end
      if (done) begin
        done_count++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (y_valid) begin
        if (first_valid < 0) first_valid = cyc;
        check("rd_en_during_out", rd_en, 0);
        if (sb.size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL unexpected_result: row %0d data %0d with empty scoreboard", y_row, y_data);
        end else begin
          check("y_data", $signed(y_data), $signed(sb[0].y));
          check("y_row", y_row, sb[0].row);
          if (y_ready) begin
            void'(sb.pop_front());
            hs_count++;
          end
        end
      end
    end
  end

  task automatic load_vec(input int vi, input int nrows);
    for (int j = 0; j < 9; j++) wmem[j] = $signed(tbl[vi].w[j]);
    for (int j = 0; j < 3; j++) xmem[j] = $signed(tbl[vi].x[j]);
    for (int rr = 0; rr < nrows; rr++) sb.push_back('{row: 2'(rr), y: tbl[vi].y[rr]});
    rd_count = 0; hs_count = 0; done_count = 0;
    first_valid = -1; done_cyc = -1; addr_idx = 0;
  endtask

  task automatic run_pass(input int vi, input bit stall, input bit repulse,
                          input int exp_done, input string tag);
    int s;
    int stall_left;
    load_vec(vi, 3);
    stall_left = stall ? 4 : 0;
    @(negedge clk);
    s = cyc;
    for (int k = 0; k < 80; k++) begin
      start = (k == 0) || (repulse && (k == 2 || k == 5 || k == 16));
      if (stall_left > 0 && y_valid && y_row == 2'd1) begin
        y_ready = 1'b0;
        stall_left--;
      end else begin
        y_ready = 1'b1;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    y_ready = 1'b1;
    if (done_cyc < 0) begin
      ncmp++;
      nfail++;
      $display("FAIL %s_timeout: no done within budget, expected at start+%0d", tag, exp_done);
    end
    check({tag, "_first_valid"}, first_valid - s, 5);
    check({tag, "_done_latency"}, done_cyc - s, exp_done);
    check({tag, "_rd_count"}, rd_count, 9);
    check({tag, "_handshakes"}, hs_count, 3);
    check({tag, "_done_count"}, done_count, 1);
    check({tag, "_sb_left"}, sb.size(), 0);
    check({tag, "_busy_after"}, busy, 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int sum;
    rst = 1'b1; start = 1'b0; y_ready = 1'b1;
    for (int j = 0; j < 16; j++) wmem[j] = '0;
    for (int j = 0; j < 4; j++) xmem[j] = '0;

    // Case table: W row-major, x, expected y per row
    for (int j = 0; j < 9; j++) tbl[0].w[j] = 8'(j + 1);
    for (int j = 0; j < 3; j++) tbl[0].x[j] = 8'(j + 1);
    tbl[0].y[0] = 18'(14); tbl[0].y[1] = 18'(32); tbl[0].y[2] = 18'(50);
    for (int j = 0; j < 9; j++) tbl[1].w[j] = 8'h80;
    for (int j = 0; j < 3; j++) tbl[1].x[j] = 8'h80;
    for (int j = 0; j < 3; j++) tbl[1].y[j] = 18'(49152);
    for (int j = 0; j < 9; j++) tbl[2].w[j] = 8'd127;
    for (int j = 0; j < 3; j++) tbl[2].x[j] = 8'h80;
    for (int j = 0; j < 3; j++) tbl[2].y[j] = 18'(-48768);
    tbl[3].w = {8'(-9), 8'(8), 8'(-7), 8'(6), 8'(-5), 8'(4), 8'(-3), 8'(2), 8'(-1)};
    tbl[3].x = {8'(30), 8'(-20), 8'(10)};
    tbl[3].y[0] = 18'(-140); tbl[3].y[1] = 18'(320); tbl[3].y[2] = 18'(-500);
    for (int j = 0; j < 9; j++) tbl[4].w[j] = 8'($urandom_range(0, 255));
    for (int j = 0; j < 3; j++) tbl[4].x[j] = 8'($urandom_range(0, 255));
    for (int rr = 0; rr < 3; rr++) begin
      sum = 0;
      for (int cc = 0; cc < 3; cc++)
        sum += int'($signed(tbl[4].w[rr*3+cc])) * int'($signed(tbl[4].x[cc]));
      tbl[4].y[rr] = 18'(sum);
    end

    rd_count = 0; hs_count = 0; done_count = 0;
    first_valid = -1; done_cyc = -1; addr_idx = 0;

    repeat (3) @(negedge clk);
    check_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    // Table-driven passes with y_ready held high
    for (int i = 0; i < 5; i++) run_pass(i, 1'b0, 1'b0, 16, $sformatf("vec%0d", i));

    // Backpressure on row 1 for four cycles
    run_pass(0, 1'b1, 1'b0, 20, "stall");

    // start re-pulsed during RUN, OUT and FIN
    run_pass(0, 1'b0, 1'b1, 16, "repulse");
    repeat (2) @(negedge clk);
    check("repulse_idle_busy", busy, 0);
    check("repulse_idle_rd_en", rd_en, 0);

    // Reset in the middle of row 1's RUN phase
    load_vec(0, 1);
    @(negedge clk);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && cyc < s + 7; k++) @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    check("rst_mid_rd_en_before", rd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid");
    check("rst_mid_handshakes", hs_count, 1);
    check("rst_mid_done_count", done_count, 0);
    check("rst_mid_sb_left", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    check_idle("rst_mid_settled");
    run_pass(0, 1'b0, 1'b0, 16, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
